// File: rtl/hazard_ctrl.sv
// Issue/hazard controller: register scoreboard, branch flush, and HALT drain
// sequencing in front of the execute stage.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [6:0]  dec_opcode,
    input  logic [3:0]  dec_rn,
    input  logic [3:0]  dec_rm,
    input  logic [3:0]  dec_rs,
    input  logic [3:0]  dec_rd,
    input  logic        ex_branch_taken,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    input  logic        resume,
    output logic        dec_ready,
    output logic        issue_valid,
    output logic        flush,
    output logic        halted,
    output logic [15:0] busy_mask,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [6:0] OP_HALT = 7'b0000001;

    logic [1:0]  state, state_nxt;
    logic        rd_rn, rd_rm, rd_rs, rd_rd, wr_rd, wr_r14;
    logic        hazard, is_halt;
    logic        issue, stall;
    logic        ready_c, issue_c, flush_c;
    logic [15:0] set_mask, clr_mask;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        rd_rn  = 1'b0;
        rd_rm  = 1'b0;
        rd_rs  = 1'b0;
        rd_rd  = 1'b0;
        wr_rd  = 1'b0;
        wr_r14 = 1'b0;
        case (dec_opcode)
            7'b0000000, 7'b1000000: wr_rd = 1'b1;
            7'b0000100, 7'b0001001, 7'b0001011, 7'b0001100, 7'b0001101,
            7'b1100000: begin
                rd_rn = 1'b1;
                wr_rd = 1'b1;
            end
            7'b0001010: rd_rn = 1'b1;
            7'b0010000: begin
                rd_rm = 1'b1;
                wr_rd = 1'b1;
            end
            7'b0011000, 7'b0011001, 7'b0011011, 7'b0011100, 7'b0011101,
            7'b1101000: begin
                rd_rn = 1'b1;
                rd_rm = 1'b1;
                wr_rd = 1'b1;
            end
            7'b0011010: begin
                rd_rn = 1'b1;
                rd_rm = 1'b1;
            end
            7'b0110000: begin
                rd_rm = 1'b1;
                rd_rs = 1'b1;
                wr_rd = 1'b1;
            end
            7'b0111000, 7'b0111001, 7'b0111011, 7'b0111100, 7'b0111101: begin
                rd_rn = 1'b1;
                rd_rm = 1'b1;
                rd_rs = 1'b1;
                wr_rd = 1'b1;
            end
            7'b0111010: begin
                rd_rn = 1'b1;
                rd_rm = 1'b1;
                rd_rs = 1'b1;
            end
            7'b1110000: begin
                rd_rn = 1'b1;
                rd_rd = 1'b1;
            end
            7'b1111000: begin
                rd_rn = 1'b1;
                rd_rm = 1'b1;
                rd_rd = 1'b1;
            end
            7'b1001100: wr_r14 = 1'b1;
            7'b1001001: rd_rm = 1'b1;
            7'b1001101: begin
                rd_rm  = 1'b1;
                wr_r14 = 1'b1;
            end
            default: ;
        endcase
    end

    // Scoreboard lookup is on the registered mask only; a same-cycle write-back
    // does not release a waiting instruction until the following cycle.
    assign hazard = (rd_rn  & busy_mask[dec_rn])
                  | (rd_rm  & busy_mask[dec_rm])
                  | (rd_rs  & busy_mask[dec_rs])
                  | ((rd_rd | wr_rd) & busy_mask[dec_rd])
                  | (wr_r14 & busy_mask[14]);

    assign is_halt = (dec_opcode == OP_HALT);

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        issue_c   = 1'b0;
        flush_c   = 1'b0;
        stall     = 1'b0;
        case (state)
            S_RUN: begin
                if (ex_branch_taken) begin
                    flush_c   = 1'b1;
                    state_nxt = S_FLUSH;
                end else if (dec_valid) begin
                    if (is_halt) begin
                        ready_c   = 1'b1;
                        state_nxt = S_DRAIN;
                    end else if (hazard) begin
                        stall = 1'b1;
                    end else begin
                        ready_c = 1'b1;
                        issue_c = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (ex_branch_taken) begin
                    flush_c   = 1'b1;
                    state_nxt = S_FLUSH;
                end else if (busy_mask == 16'h0000) begin
                    state_nxt = S_HALTED;
                end
            end
            S_FLUSH: begin
                flush_c   = 1'b1;
                state_nxt = S_RUN;
            end
            S_HALTED: begin
                if (resume) state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    assign issue       = issue_c;
    assign dec_ready   = ready_c & ~rst;
    assign issue_valid = issue_c & ~rst;
    assign flush       = flush_c & ~rst;

    assign set_mask = issue ? (({16{wr_rd}}  & (16'h0001 << dec_rd))
                             | ({16{wr_r14}} & 16'h4000))
                            : 16'h0000;
    assign clr_mask = wb_valid ? (16'h0001 << wb_rd) : 16'h0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            busy_mask <= 16'h0000;
            stall_cnt <= 16'h0000;
            halted    <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy_mask <= (busy_mask & ~clr_mask) | set_mask;
            if (stall) stall_cnt <= sat_inc16(stall_cnt);
            halted    <= (state_nxt == S_HALTED);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized plus directed bench for hazard_ctrl; a behavioural model predicts
// each cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_hazard_ctrl;

    logic        clk, rst;
    logic        dec_valid;
    logic [6:0]  dec_opcode;
    logic [3:0]  dec_rn, dec_rm, dec_rs, dec_rd;
    logic        ex_branch_taken, wb_valid, resume;
    logic [3:0]  wb_rd;
    logic        dec_ready, issue_valid, flush, halted;
    logic [15:0] busy_mask, stall_cnt;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_rs(dec_rs), .dec_rd(dec_rd),
        .ex_branch_taken(ex_branch_taken), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .resume(resume), .dec_ready(dec_ready), .issue_valid(issue_valid),
        .flush(flush), .halted(halted), .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, iv, fl, hl;
        logic [15:0] bm, sc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: 0 run, 1 flush, 2 drain, 3 halted
    int          m_state;
    logic [15:0] m_busy, m_stall;
    logic        m_halted;

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    // Register usage of an opcode expressed as read and write bitmaps
    function automatic void op_use(input logic [6:0] op, input logic [3:0] rn, rm, rs, rd,
                                   output logic [15:0] rmask, output logic [15:0] wmask);
        bit r_n, r_m, r_s, r_d, w_d, w14;
        r_n = 0; r_m = 0; r_s = 0; r_d = 0; w_d = 0; w14 = 0;
        if (op inside {7'b0000000, 7'b1000000}) w_d = 1;
        if (op inside {7'b0000100, 7'b0001001, [7'b0001011:7'b0001101], 7'b1100000}) begin r_n = 1; w_d = 1; end
        if (op == 7'b0001010) r_n = 1;
        if (op == 7'b0010000) begin r_m = 1; w_d = 1; end
        if (op inside {7'b0011000, 7'b0011001, [7'b0011011:7'b0011101], 7'b1101000}) begin r_n = 1; r_m = 1; w_d = 1; end
        if (op == 7'b0011010) begin r_n = 1; r_m = 1; end
        if (op == 7'b0110000) begin r_m = 1; r_s = 1; w_d = 1; end
        if (op inside {7'b0111000, 7'b0111001, [7'b0111011:7'b0111101]}) begin r_n = 1; r_m = 1; r_s = 1; w_d = 1; end
        if (op == 7'b0111010) begin r_n = 1; r_m = 1; r_s = 1; end
        if (op == 7'b1110000) begin r_n = 1; r_d = 1; end
        if (op == 7'b1111000) begin r_n = 1; r_m = 1; r_d = 1; end
        if (op == 7'b1001100) w14 = 1;
        if (op == 7'b1001001) r_m = 1;
        if (op == 7'b1001101) begin r_m = 1; w14 = 1; end
        rmask = 16'h0;
        wmask = 16'h0;
        if (r_n) rmask[rn] = 1'b1;
        if (r_m) rmask[rm] = 1'b1;
        if (r_s) rmask[rs] = 1'b1;
        if (r_d) rmask[rd] = 1'b1;
        if (w_d) wmask[rd] = 1'b1;
        if (w14) wmask[14] = 1'b1;
    endfunction

    // Predict this cycle's outputs, queue them, then advance the model over one edge
    task automatic tick();
        exp_t        e;
        logic [15:0] rmask, wmask, setm;
        int          nxt;
        if (rst) begin
            m_state = 0; m_busy = 0; m_stall = 0; m_halted = 0;
        end
        e.rdy = 0; e.iv = 0; e.fl = 0;
        e.hl = m_halted; e.bm = m_busy; e.sc = m_stall;
        op_use(dec_opcode, dec_rn, dec_rm, dec_rs, dec_rd, rmask, wmask);
        setm = 0;
        nxt  = m_state;
        if (!rst) begin
            if (m_state == 0) begin
                if (ex_branch_taken) begin e.fl = 1; nxt = 1; end
                else if (dec_valid && dec_opcode == 7'b0000001) begin e.rdy = 1; nxt = 2; end
                else if (dec_valid && ((rmask | wmask) & m_busy) != 0) begin
                    if (m_stall != 16'hFFFF) m_stall = m_stall + 1;
                end else if (dec_valid) begin e.rdy = 1; e.iv = 1; setm = wmask; end
            end else if (m_state == 1) begin
                e.fl = 1; nxt = 0;
            end else if (m_state == 2) begin
                if (ex_branch_taken) begin e.fl = 1; nxt = 1; end
                else if (m_busy == 0) nxt = 3;
            end else begin
                if (resume) nxt = 0;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!rst) begin
            if (wb_valid) m_busy[wb_rd] = 1'b0;
            m_busy   = m_busy | setm;
            m_state  = nxt;
            m_halted = (nxt == 3);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("dec_ready",   {15'd0, dec_ready},   {15'd0, e.rdy});
            check("issue_valid", {15'd0, issue_valid}, {15'd0, e.iv});
            check("flush",       {15'd0, flush},       {15'd0, e.fl});
            check("halted",      {15'd0, halted},      {15'd0, e.hl});
            check("busy_mask",   busy_mask,            e.bm);
            check("stall_cnt",   stall_cnt,            e.sc);
        end
    end

    task automatic idle();
        dec_valid = 0; dec_opcode = 0; dec_rn = 0; dec_rm = 0; dec_rs = 0; dec_rd = 0;
        ex_branch_taken = 0; wb_valid = 0; wb_rd = 0; resume = 0;
    endtask

    task automatic instr(input logic [6:0] op, input logic [3:0] rn, rm, rs, rd);
        dec_valid = 1; dec_opcode = op; dec_rn = rn; dec_rm = rm; dec_rs = rs; dec_rd = rd;
    endtask

    task automatic wb(input logic [3:0] r);
        wb_valid = 1; wb_rd = r;
    endtask

    logic [6:0] ops [0:13] = '{7'b0000000, 7'b0001001, 7'b0001010, 7'b0010000, 7'b0011000,
                              7'b0011010, 7'b0110000, 7'b0111010, 7'b1100000, 7'b1110000,
                              7'b1111000, 7'b1001100, 7'b1001001, 7'b1001101};

    initial begin
        m_state = 0; m_busy = 0; m_stall = 0; m_halted = 0;
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        tick(); tick();
        rst = 0;

        // Dependent ALU op waits for write-back of r3
        instr(7'b1100000, 0, 0, 0, 3); tick();
        instr(7'b0011000, 3, 1, 0, 5);
        repeat (4) tick();
        wb(3); tick();
        wb_valid = 0; tick();
        idle(); wb(5); tick();
        idle(); tick();

        // Implicit r14 writer and reader
        instr(7'b1001101, 0, 2, 0, 0); tick();
        instr(7'b1001001, 0, 14, 0, 0);
        repeat (3) tick();
        wb(14); tick();
        wb_valid = 0; tick();
        idle(); wb(14); tick();

        // Branch flush while a clean instruction waits
        idle(); instr(7'b0000000, 0, 0, 0, 7); ex_branch_taken = 1; tick();
        ex_branch_taken = 0; tick();
        tick();
        idle(); wb(7); tick();

        // HALT drains r3, halts, then resumes
        idle(); instr(7'b1000000, 0, 0, 0, 3); tick();
        instr(7'b0000001, 0, 0, 0, 0); tick();
        idle(); repeat (3) tick();
        wb(3); tick();
        idle(); repeat (3) tick();
        resume = 1; tick();
        resume = 0; tick();

        // Branch during DRAIN cancels the halt
        instr(7'b1000000, 0, 0, 0, 4); tick();
        instr(7'b0000001, 0, 0, 0, 0); tick();
        idle(); tick();
        ex_branch_taken = 1; tick();
        ex_branch_taken = 0; repeat (3) tick();
        wb(4); tick();
        idle(); tick();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            dec_valid  = ($urandom_range(0, 3) != 0);
            dec_opcode = ($urandom_range(0, 15) == 0) ? 7'b0000001 :
                         ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 13)];
            dec_rn = 4'($urandom); dec_rm = 4'($urandom);
            dec_rs = 4'($urandom); dec_rd = 4'($urandom);
            ex_branch_taken = ($urandom_range(0, 15) == 0);
            wb_valid = ($urandom_range(0, 1) == 0);
            wb_rd    = 4'($urandom);
            resume   = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle(); rst = 1; tick();
        rst = 0; tick();

        // Long stall saturates the counter, then reset mid-DRAIN
        instr(7'b1100000, 0, 0, 0, 3); tick();
        instr(7'b0011000, 3, 1, 0, 5);
        repeat (65540) tick();
        instr(7'b0000001, 0, 0, 0, 0); tick();
        idle(); tick();
        rst = 1; tick();
        rst = 0; tick();
        tick();

        @(negedge clk);
        #1;
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
